// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with a guard gap between grants and serial line routing.
// Optional forced-release timeout is compiled in with `define ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int GUARD_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic m1_req,
    input  logic m2_req,
    input  logic m1_tx,
    input  logic m2_tx,
    input  logic bus_rx,
    output logic m1_grant,
    output logic m2_grant,
    output logic bus_tx,
    output logic m1_rx,
    output logic m2_rx,
    output logic bus_busy,
    output logic timeout
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT1 = 2'd1,
        ST_GRANT2 = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(GUARD_CYCLES - 1);

    if (GUARD_CYCLES < 1 || GUARD_CYCLES > 15 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("bus_arbiter: parameter out of legal range");
    end

    state_t     state_r, state_nxt_s;
    logic       last_served_r, last_served_nxt_s;   // 1'b0 = master1, 1'b1 = master2
    logic [3:0] gap_cnt_r, gap_cnt_nxt_s;
    logic       m1_grant_r, m2_grant_r, bus_busy_r;
    logic       m1_grant_nxt_s, m2_grant_nxt_s, bus_busy_nxt_s;
    logic       expire_s;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt_r;
    logic        timeout_r;

    // Grant-length counter and one-cycle forced-release pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt_r <= 16'd0;
            timeout_r <= 1'b0;
        end else begin
            if (state_r == ST_GRANT1 || state_r == ST_GRANT2) begin
                tmo_cnt_r <= tmo_cnt_r + 16'd1;
            end else begin
                tmo_cnt_r <= 16'd0;
            end
            timeout_r <= expire_s & (((state_r == ST_GRANT1) & m1_req) |
                                     ((state_r == ST_GRANT2) & m2_req));
        end
    end

    assign expire_s = (tmo_cnt_r == TMO_LAST);
    assign timeout  = timeout_r;
`else
    assign expire_s = 1'b0;
    assign timeout  = 1'b0;
`endif

    // State, arbitration history, gap counter and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= ST_IDLE;
            last_served_r <= 1'b1;
            gap_cnt_r     <= 4'd0;
            m1_grant_r    <= 1'b0;
            m2_grant_r    <= 1'b0;
            bus_busy_r    <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            last_served_r <= last_served_nxt_s;
            gap_cnt_r     <= gap_cnt_nxt_s;
            m1_grant_r    <= m1_grant_nxt_s;
            m2_grant_r    <= m2_grant_nxt_s;
            bus_busy_r    <= bus_busy_nxt_s;
        end
    end

    // Next-state: requests are only looked at in IDLE, a grant ends on release or expiry
    always_comb begin
        state_nxt_s       = state_r;
        last_served_nxt_s = last_served_r;
        gap_cnt_nxt_s     = gap_cnt_r;
        case (state_r)
            ST_IDLE: begin
                gap_cnt_nxt_s = 4'd0;
                if (m1_req && m2_req) begin
                    state_nxt_s = last_served_r ? ST_GRANT1 : ST_GRANT2;
                end else if (m1_req) begin
                    state_nxt_s = ST_GRANT1;
                end else if (m2_req) begin
                    state_nxt_s = ST_GRANT2;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT1: begin
                if (!m1_req || expire_s) begin
                    state_nxt_s       = ST_GAP;
                    last_served_nxt_s = 1'b0;
                    gap_cnt_nxt_s     = 4'd0;
                end else begin
                    state_nxt_s = ST_GRANT1;
                end
            end
            ST_GRANT2: begin
                if (!m2_req || expire_s) begin
                    state_nxt_s       = ST_GAP;
                    last_served_nxt_s = 1'b1;
                    gap_cnt_nxt_s     = 4'd0;
                end else begin
                    state_nxt_s = ST_GRANT2;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_nxt_s   = ST_IDLE;
                    gap_cnt_nxt_s = 4'd0;
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r + 4'd1;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                gap_cnt_nxt_s = 4'd0;
            end
        endcase
    end

    // Outputs: next registered flags, plus line routing from the current state
    always_comb begin
        m1_grant_nxt_s = (state_nxt_s == ST_GRANT1);
        m2_grant_nxt_s = (state_nxt_s == ST_GRANT2);
        bus_busy_nxt_s = (state_nxt_s != ST_IDLE);
        case (state_r)
            ST_GRANT1: begin
                bus_tx = m1_tx;
                m1_rx  = bus_rx;
                m2_rx  = 1'b1;
            end
            ST_GRANT2: begin
                bus_tx = m2_tx;
                m1_rx  = 1'b1;
                m2_rx  = bus_rx;
            end
            default: begin
                bus_tx = 1'b1;
                m1_rx  = 1'b1;
                m2_rx  = 1'b1;
            end
        endcase
    end

    assign m1_grant = m1_grant_r;
    assign m2_grant = m2_grant_r;
    assign bus_busy = bus_busy_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expected output-change events are queued by the
// stimulus, a negedge monitor pops and compares each change the DUT presents.
`timescale 1ps/1ps
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rstn, m1_req, m2_req, m1_tx, m2_tx, bus_rx;
    logic m1_grant, m2_grant, bus_tx, m1_rx, m2_rx, bus_busy, timeout;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic [3:0] vec;   // {m1_grant, m2_grant, bus_busy, timeout}
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] prev_vec = 4'b0000;

    bus_arbiter #(.GUARD_CYCLES(2), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rstn(rstn),
        .m1_req(m1_req), .m2_req(m2_req),
        .m1_tx(m1_tx), .m2_tx(m2_tx), .bus_rx(bus_rx),
        .m1_grant(m1_grant), .m2_grant(m2_grant),
        .bus_tx(bus_tx), .m1_rx(m1_rx), .m2_rx(m2_rx),
        .bus_busy(bus_busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_at(input int off, input logic [3:0] v);
        exp_t e;
        e.cyc = cyc + off;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every change of the flag vector must match the head of the queue
    always @(negedge clk) begin : monitor
        logic [3:0] v;
        exp_t       e;
        v = {m1_grant, m2_grant, bus_busy, timeout};
        if (v !== prev_vec) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: cyc=%0d got %b, required no change", cyc, v);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.vec !== v) begin
                    n_err++;
                    $display("FAIL event: cyc=%0d got %b, required cyc=%0d vec=%b",
                             cyc, v, e.cyc, e.vec);
                end
            end
            prev_vec = v;
        end
    end

    initial begin
        logic [2:0] pat;
        pat    = 3'b101;
        rstn   = 1'b1;
        m1_req = 1'b0;
        m2_req = 1'b0;
        m1_tx  = 1'b0;
        m2_tx  = 1'b0;
        bus_rx = 1'b0;
        #1 rstn = 1'b0;

        // Reset state
        #21;
        chk("rst_m1_grant", m1_grant, 1'b0);
        chk("rst_m2_grant", m2_grant, 1'b0);
        chk("rst_bus_busy", bus_busy, 1'b0);
        chk("rst_timeout",  timeout,  1'b0);
        chk("rst_bus_tx",   bus_tx,   1'b1);
        chk("rst_m1_rx",    m1_rx,    1'b1);
        chk("rst_m2_rx",    m2_rx,    1'b1);
        @(negedge clk);                 // t=30
        rstn = 1'b1;

        // Single master1 transaction, request at 40 ps, release at 120 ps
        @(negedge clk);                 // t=40
        m1_req = 1'b1;
        expect_at(1, 4'b1010);
        negs(2);
        m1_tx = 1'b1;
        #1 chk("g1_bus_tx_hi", bus_tx, 1'b1);
        m1_tx = 1'b0;
        #1 chk("g1_bus_tx_lo", bus_tx, 1'b0);
        bus_rx = 1'b0;
        #1 chk("g1_m1_rx", m1_rx, 1'b0);
        chk("g1_m2_rx", m2_rx, 1'b1);
        negs(6);                        // t=120
        m1_req = 1'b0;
        expect_at(1, 4'b0010);
        expect_at(3, 4'b0000);
        negs(4);

        // Reset, then simultaneous requests: master1 first, then master2 by round robin
        rstn = 1'b0;
        negs(1);
        rstn   = 1'b1;
        m1_req = 1'b1;
        m2_req = 1'b1;
        expect_at(1, 4'b1010);
        negs(3);
        m1_req = 1'b0;
        expect_at(1, 4'b0010);
        expect_at(3, 4'b0000);
        expect_at(4, 4'b0110);
        negs(1);
        m1_req = 1'b1;
        negs(3);

        // Master2 owns the bus; master1 keeps requesting without effect
        m1_tx  = 1'b0;
        bus_rx = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m2_tx = pat[i];
            #1;
            chk("g2_bus_tx", bus_tx, pat[i]);
            chk("g2_m1_rx",  m1_rx,  1'b1);
            chk("g2_m2_rx",  m2_rx,  1'b0);
            @(negedge clk);
        end
        m2_req = 1'b0;
        expect_at(1, 4'b0010);
        expect_at(3, 4'b0000);
        expect_at(4, 4'b1010);
        negs(6);

        // master2 requests during GAP and is granted only after IDLE
        m1_req = 1'b0;
        expect_at(1, 4'b0010);
        negs(1);
        m2_req = 1'b1;
        expect_at(2, 4'b0000);
        expect_at(3, 4'b0110);
        negs(3);
        m2_req = 1'b0;
        m1_req = 1'b1;
        expect_at(1, 4'b0010);
        expect_at(3, 4'b0000);
        expect_at(4, 4'b1010);
        negs(4);

        // Asynchronous reset in the middle of a master1 grant
        m1_tx = 1'b0;
        expect_at(1, 4'b0000);
        #2 rstn = 1'b0;
        #1;
        chk("arst_m1_grant", m1_grant, 1'b0);
        chk("arst_bus_tx",   bus_tx,   1'b1);
        chk("arst_bus_busy", bus_busy, 1'b0);
        chk("arst_m1_rx",    m1_rx,    1'b1);
        negs(2);
        rstn = 1'b1;
        expect_at(1, 4'b1010);
        negs(2);
        m1_req = 1'b0;
        expect_at(1, 4'b0010);
        expect_at(3, 4'b0000);
        negs(4);

        // Long grant: forced release when the timeout is built in, untouched otherwise
        m1_req = 1'b1;
`ifdef ARB_TIMEOUT_EN
        expect_at(1,  4'b1010);
        expect_at(9,  4'b0011);
        expect_at(10, 4'b0010);
        expect_at(11, 4'b0000);
        expect_at(12, 4'b1010);
        negs(13);
`else
        expect_at(1, 4'b1010);
        negs(20);
`endif
        m1_req = 1'b0;
        expect_at(1, 4'b0010);
        expect_at(3, 4'b0000);
        negs(5);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_events: got %0d left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
